// File: rtl/img_rx_wr.sv
// Turns the UART byte stream into RGB565 pixels and writes them to the frame buffer.
// led toggles once for every frame that has been completely written.
module img_rx_wr #(
  parameter int PIX_TOTAL = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [15:0]       ram_wrdata,
  output logic              led
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_TOTAL - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  typedef enum logic {
    PH_HIGH,
    PH_LOW
  } phase_t;

  phase_t            phase;
  phase_t            phase_next;
  logic              capture_high;
  logic              write_pixel;
  logic [ADDR_W-1:0] pix_cnt;

  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      phase <= PH_HIGH;
    end else begin
      phase <= phase_next;
    end
  end

  always_comb begin
    phase_next   = phase;
    capture_high = 1'b0;
    write_pixel  = 1'b0;
    if (rx_done) begin
      case (phase)
        PH_HIGH: begin
          capture_high = 1'b1;
          phase_next   = PH_LOW;
        end
        PH_LOW: begin
          write_pixel = 1'b1;
          phase_next  = PH_HIGH;
        end
        default: phase_next = PH_HIGH;
      endcase
    end
  end

  // The high byte is latched into ram_wrdata early; the RAM ignores it until ram_wren.
  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_wrdata <= '0;
      led        <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      ram_wren <= write_pixel;
      if (capture_high) begin
        ram_wrdata[15:8] <= rx_data;
      end
      if (write_pixel) begin
        ram_wrdata[7:0] <= rx_data;
        ram_wraddr      <= pix_cnt;
        if (pix_cnt == LAST_ADDR) begin
          pix_cnt <= '0;
          led     <= ~led;
        end else begin
          pix_cnt <= pix_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_img_rx_wr.sv
// Directed bench for img_rx_wr with a small frame so the wrap and led toggles are reachable.
module tb_img_rx_wr;

  localparam int PIX_TOTAL = 8;
  localparam int ADDR_W    = 4;

  logic              Clk;
  logic              Reset_n;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [15:0]       ram_wrdata;
  logic              led;

  int assert_count;
  int fail_count;

  typedef struct {
    logic              rst;
    logic              done;
    logic [7:0]        data;
    logic              exp_wren;
    logic [ADDR_W-1:0] exp_addr;
    logic [15:0]       exp_data;
    logic              exp_led;
  } vec_t;

  vec_t vecs[$];

  img_rx_wr #(
    .PIX_TOTAL(PIX_TOTAL),
    .ADDR_W   (ADDR_W)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .ram_wren  (ram_wren),
    .ram_wraddr(ram_wraddr),
    .ram_wrdata(ram_wrdata),
    .led       (led)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic add_vec(input logic rst, input logic done, input logic [7:0] data,
                         input logic wren, input logic [ADDR_W-1:0] addr,
                         input logic [15:0] wdata, input logic l);
    vec_t v;
    v.rst = rst; v.done = done; v.data = data;
    v.exp_wren = wren; v.exp_addr = addr; v.exp_data = wdata; v.exp_led = l;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic wren, input logic [ADDR_W-1:0] addr,
                              input logic [15:0] wdata, input logic l);
    assert_count++;
    if (ram_wren !== wren || ram_wraddr !== addr || ram_wrdata !== wdata || led !== l) begin
      fail_count++;
      $display("[TB] FAIL %s: got wren=%0b addr=%h data=%h led=%0b, expected wren=%0b addr=%h data=%h led=%0b",
               name, ram_wren, ram_wraddr, ram_wrdata, led, wren, addr, wdata, l);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit after the next one.
  task automatic apply_stimulus(input logic rst, input logic done, input logic [7:0] data);
    Reset_n = rst;
    rx_done = done;
    rx_data = data;
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  initial begin
    logic [ADDR_W-1:0] addr;
    logic              exp_led;
    logic [7:0]        hi;
    logic [7:0]        lo;

    assert_count = 0;
    fail_count   = 0;
    Reset_n = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;

    // reset
    add_vec(1, 0, 8'h00, 0, 4'd0, 16'h0000, 0);
    add_vec(1, 0, 8'h00, 0, 4'd0, 16'h0000, 0);
    // three pixels
    add_vec(0, 1, 8'hAA, 0, 4'd0, 16'hAA00, 0);
    add_vec(0, 1, 8'hBB, 1, 4'd0, 16'hAABB, 0);
    add_vec(0, 0, 8'h00, 0, 4'd0, 16'hAABB, 0);
    add_vec(0, 1, 8'hCC, 0, 4'd0, 16'hCCBB, 0);
    add_vec(0, 1, 8'hDD, 1, 4'd1, 16'hCCDD, 0);
    add_vec(0, 1, 8'hEE, 0, 4'd1, 16'hEEDD, 0);
    add_vec(0, 1, 8'hFF, 1, 4'd2, 16'hEEFF, 0);
    add_vec(0, 0, 8'h00, 0, 4'd2, 16'hEEFF, 0);
    // odd byte then completion
    add_vec(0, 1, 8'h11, 0, 4'd2, 16'h11FF, 0);
    add_vec(0, 0, 8'h5A, 0, 4'd2, 16'h11FF, 0);
    add_vec(0, 0, 8'h00, 0, 4'd2, 16'h11FF, 0);
    add_vec(0, 1, 8'h22, 1, 4'd3, 16'h1122, 0);
    // back-to-back strobes
    add_vec(0, 1, 8'h01, 0, 4'd3, 16'h0122, 0);
    add_vec(0, 1, 8'h02, 1, 4'd4, 16'h0102, 0);
    add_vec(0, 1, 8'h03, 0, 4'd4, 16'h0302, 0);
    add_vec(0, 1, 8'h04, 1, 4'd5, 16'h0304, 0);
    add_vec(0, 0, 8'h00, 0, 4'd5, 16'h0304, 0);
    // frame end and wrap
    add_vec(0, 1, 8'h11, 0, 4'd5, 16'h1104, 0);
    add_vec(0, 1, 8'h22, 1, 4'd6, 16'h1122, 0);
    add_vec(0, 1, 8'h11, 0, 4'd6, 16'h1122, 0);
    add_vec(0, 1, 8'h22, 1, 4'd7, 16'h1122, 1);
    add_vec(0, 1, 8'h11, 0, 4'd7, 16'h1122, 1);
    add_vec(0, 1, 8'h22, 1, 4'd0, 16'h1122, 1);
    add_vec(0, 0, 8'h00, 0, 4'd0, 16'h1122, 1);
    // mid-pixel reset, reset wins over a simultaneous strobe
    add_vec(0, 1, 8'hAA, 0, 4'd0, 16'hAA22, 1);
    add_vec(1, 1, 8'h55, 0, 4'd0, 16'h0000, 0);
    add_vec(0, 1, 8'hBB, 0, 4'd0, 16'hBB00, 0);
    add_vec(0, 1, 8'hCC, 1, 4'd0, 16'hBBCC, 0);
    add_vec(0, 0, 8'h00, 0, 4'd0, 16'hBBCC, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].done, vecs[i].data);
      check_output($sformatf("vec%0d", i), vecs[i].exp_wren, vecs[i].exp_addr,
                   vecs[i].exp_data, vecs[i].exp_led);
    end

    // rx_done held high for three cycles counts as three identical bytes
    apply_stimulus(0, 1, 8'h77);
    check_output("held1", 0, 4'd0, 16'h77CC, 0);
    apply_stimulus(0, 1, 8'h77);
    check_output("held2", 1, 4'd1, 16'h7777, 0);
    apply_stimulus(0, 1, 8'h77);
    check_output("held3", 0, 4'd1, 16'h7777, 0);
    apply_stimulus(0, 1, 8'h88);
    check_output("held4", 1, 4'd2, 16'h7788, 0);

    // two more full frames: led goes high at addr 7, then low again a frame later
    exp_led = 1'b0;
    for (int p = 0; p < 16; p++) begin
      addr = ADDR_W'((3 + p) % PIX_TOTAL);
      hi   = 8'(p + 8'h30);
      lo   = ~hi;
      if (addr == ADDR_W'(PIX_TOTAL - 1)) exp_led = ~exp_led;
      apply_stimulus(0, 1, hi);
      check_output($sformatf("frame_hi%0d", p), 0, ADDR_W'((2 + p) % PIX_TOTAL),
                   {hi, ram_wrdata_prev_lo(p)}, (p >= 5 && p < 13));
      apply_stimulus(0, 1, lo);
      check_output($sformatf("frame_lo%0d", p), 1, addr, {hi, lo}, exp_led);
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Low byte left in ram_wrdata before pixel p of the frame loop: 0x88 initially, else ~(previous hi).
  function automatic logic [7:0] ram_wrdata_prev_lo(input int p);
    logic [7:0] prev_hi;
    if (p == 0) return 8'h88;
    prev_hi = 8'(p - 1 + 8'h30);
    return ~prev_hi;
  endfunction

endmodule

// File: doc/img_rx_wr.md
Name: img_rx_wr

Overview:
- Assembles a byte stream from the UART receiver into 16-bit RGB565 pixels.
- Writes each pixel into the frame-buffer RAM at sequential addresses.
- Toggles a status LED each time a full frame has been written.
- Sits between the UART RX block and the dual-port image RAM read by the TFT controller.

Parameters:
- PIX_TOTAL, 65536, pixels per frame (1..65536); address wraps to 0 after PIX_TOTAL-1.
- ADDR_W, 16, width of ram_wraddr.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  synchronous, active-high reset. The name follows codebase convention; the polarity is high-active.
- rx_data  input  8  received byte; valid in the cycle rx_done is high.
- rx_done  input  1  single-cycle byte strobe; every cycle it is high counts as one byte.
- ram_wren  output  1  one-cycle RAM write enable.
- ram_wraddr  output  ADDR_W  RAM write address.
- ram_wrdata  output  16  RAM write data {first byte, second byte}.
- led  output  1  frame-complete indicator; toggles per completed frame.

Behaviour:
- All outputs and state are registered. Reset is sampled on the clock edge when Reset_n=1.
- Reset values: ram_wren=0, ram_wraddr=0, ram_wrdata=0, led=0, byte phase=0 (expecting high byte), pixel counter=0.
- Byte phase 0, rx_done=1:
  - ram_wrdata[15:8] <= rx_data.
  - phase <= 1.
  - no write.
- Byte phase 1, rx_done=1:
  - ram_wrdata[7:0] <= rx_data.
  - ram_wraddr <= pixel counter.
  - ram_wren <= 1 for exactly the next cycle.
  - phase <= 0.
  - pixel counter advances.
- Latency: second-byte strobe sampled at edge k. At k+1, ram_wren=1 with ram_wrdata and ram_wraddr valid. At k+2, ram_wren=0.
- ram_wren is high for one cycle per pixel, never on a first byte.
- ram_wraddr and ram_wrdata hold their values between writes.
- ram_wrdata[15:8] updates on the first byte, before the write. The RAM must only sample data when ram_wren=1.
- Pixel counter: increments by 1 per completed pixel. When a pixel is written at address PIX_TOTAL-1, the counter returns to 0 (no overflow past PIX_TOTAL-1).
- led toggles in the same cycle as the ram_wren of the pixel at address PIX_TOTAL-1.
- rx_done held high for N consecutive cycles equals N bytes of the same value.
- rx_done=0: nothing changes except ram_wren returning to 0.
- Reset mid-pixel: a pending high byte is discarded and phase returns to 0. Reset in the same cycle as rx_done: reset wins and the byte is ignored.
- Reset mid-frame: addressing restarts at 0 and led clears to 0.
- No back-pressure. Bytes may arrive on consecutive cycles, and back-to-back pixels produce ram_wren on alternating cycles.

Test Plan:
- Reset: assert Reset_n for 2 cycles -> ram_wren=0, ram_wraddr=0, ram_wrdata=0, led=0.
- Pixel assembly:
  - Stimulus: strobes AA, BB, CC, DD, EE, FF.
  - Response: three single-cycle ram_wren pulses, each one cycle after BB, DD and FF.
  - Values: (addr 0, AABB), (addr 1, CCDD), (addr 2, EEFF).
- Odd byte: send 11 only -> no ram_wren. Then send 22 -> write 0x1122 at the next address.
- Full frame and wrap (PIX_TOTAL=65536):
  - Stimulus: after the three pixels above, send pairs 11,22 repeatedly.
  - Response: led toggles to 1 on the write at addr FFFF. The next pixel writes 0x1122 at addr 0000. led toggles back after a further 65536 pixels.
- Back-to-back: rx_done high on 4 consecutive cycles (01, 02, 03, 04) -> writes 0x0102 and 0x0304 at consecutive addresses, with ram_wren high on alternating cycles.
- Mid-pixel reset: send AA, reset, then send BB, CC -> first write is 0xBBCC at addr 0, and led=0.
